// File: rtl/ahb_gpio_multi.sv
// AHB-Lite zero-wait-state GPIO with per-bit direction, atomic set/clear,
// multi-stage input synchroniser and sticky edge-detect interrupts.
module ahb_gpio_multi #(
    parameter int GPIO_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    input  logic [GPIO_WIDTH-1:0] GPIOIN,
    output logic [GPIO_WIDTH-1:0] GPIOOUT,
    output logic [GPIO_WIDTH-1:0] GPIOOEN,
    output logic                  GPIOINT
);

    typedef logic [GPIO_WIDTH-1:0] gpio_t;

    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_DIR     = 3'd1;
    localparam logic [2:0] A_OUTSET  = 3'd2;
    localparam logic [2:0] A_OUTCLR  = 3'd3;
    localparam logic [2:0] A_INTEN   = 3'd4;
    localparam logic [2:0] A_INTPOL  = 3'd5;
    localparam logic [2:0] A_INTSTAT = 3'd6;

    function automatic logic [31:0] zext(input gpio_t v);
        logic [31:0] r;
        r = '0;
        r[GPIO_WIDTH-1:0] = v;
        return r;
    endfunction

    logic [2:0]  addr_p1;
    logic        write_p1;
    logic        vld_p1;
    logic        wr_en;
    gpio_t       dataout, dir, inten, intpol, intstat;
    gpio_t       sync_q [SYNC_STAGES];
    gpio_t       syncin, syncin_d;
    gpio_t       wdata, rise, fall, evt, w1c;
    logic [31:0] rdata;
    logic        unused_bits;

    // Address phase -> data phase
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            addr_p1  <= '0;
            write_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= HSEL & HTRANS[1] & HREADY;
            if (HSEL && HTRANS[1] && HREADY) begin
                addr_p1  <= HADDR[4:2];
                write_p1 <= HWRITE;
            end
        end
    end

    // Pad synchroniser and edge history
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            syncin_d <= '0;
        end else begin
            sync_q[0] <= GPIOIN;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            syncin_d <= syncin;
        end
    end

    assign syncin = sync_q[SYNC_STAGES-1];
    assign rise   = syncin & ~syncin_d;
    assign fall   = ~syncin & syncin_d;
    assign evt    = ~dir & ((intpol & rise) | (~intpol & fall));

    assign wdata  = HWDATA[GPIO_WIDTH-1:0];
    assign wr_en  = vld_p1 & write_p1;
    assign w1c    = (wr_en && addr_p1 == A_INTSTAT) ? wdata : '0;

    // Register file; edge events take priority over a same-cycle W1C
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dataout <= '0;
            dir     <= '0;
            inten   <= '0;
            intpol  <= '0;
            intstat <= '0;
        end else begin
            if (wr_en) begin
                case (addr_p1)
                    A_DATA:   dataout <= wdata;
                    A_DIR:    dir     <= wdata;
                    A_OUTSET: dataout <= dataout | wdata;
                    A_OUTCLR: dataout <= dataout & ~wdata;
                    A_INTEN:  inten   <= wdata;
                    A_INTPOL: intpol  <= wdata;
                    default:  ;
                endcase
            end
            intstat <= (intstat & ~w1c) | evt;
        end
    end

    always_comb begin
        rdata = '0;
        if (vld_p1 && !write_p1) begin
            case (addr_p1)
                A_DATA:    rdata = zext((dir & dataout) | (~dir & syncin));
                A_DIR:     rdata = zext(dir);
                A_INTEN:   rdata = zext(inten);
                A_INTPOL:  rdata = zext(intpol);
                A_INTSTAT: rdata = zext(intstat);
                default:   rdata = '0;
            endcase
        end
    end

    assign HRDATA      = rdata;
    assign HREADYOUT   = 1'b1;
    assign GPIOOUT     = dataout;
    assign GPIOOEN     = dir;
    assign GPIOINT     = |(intstat & inten);
    assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

endmodule

// File: tb/tb_ahb_gpio_multi.sv
// Directed bench for ahb_gpio_multi: a 16-bit instance plus an 8-bit instance
// sharing the bus, checked with immediate assertions.
module tb_ahb_gpio_multi;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic        HSEL8 = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic        HREADYOUT, HREADYOUT8;
    logic [31:0] HRDATA, HRDATA8;
    logic [15:0] GPIOIN = '0;
    logic [15:0] GPIOOUT, GPIOOEN;
    logic [7:0]  GPIOIN8 = '0;
    logic [7:0]  GPIOOUT8, GPIOOEN8;
    logic        GPIOINT, GPIOINT8;

    int checks = 0;
    int failures = 0;
    logic [31:0] rd;

    always #5 HCLK = ~HCLK;

    ahb_gpio_multi #(.GPIO_WIDTH(16), .SYNC_STAGES(2)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .GPIOIN(GPIOIN),
        .GPIOOUT(GPIOOUT), .GPIOOEN(GPIOOEN), .GPIOINT(GPIOINT)
    );

    ahb_gpio_multi #(.GPIO_WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL8), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT8), .HRDATA(HRDATA8), .GPIOIN(GPIOIN8),
        .GPIOOUT(GPIOOUT8), .GPIOOEN(GPIOOEN8), .GPIOINT(GPIOINT8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HSEL8 = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1;
    endtask

    task automatic bus_write(input bit s8, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] tr = 2'b10, input logic rdy = 1'b1);
        @(negedge HCLK);
        HSEL = !s8; HSEL8 = s8; HTRANS = tr; HREADY = rdy; HWRITE = 1'b1; HADDR = addr;
        @(negedge HCLK);
        bus_idle();
        HWDATA = data;
        @(negedge HCLK);
    endtask

    task automatic bus_read(input bit s8, input logic [31:0] addr, output logic [31:0] data);
        @(negedge HCLK);
        HSEL = !s8; HSEL8 = s8; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(negedge HCLK);
        bus_idle();
        data = s8 ? HRDATA8 : HRDATA;
    endtask

    initial begin
        // Reset held over three rising edges
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        chk("rst_gpioout", {16'h0, GPIOOUT}, 32'h0);
        chk("rst_gpiooen", {16'h0, GPIOOEN}, 32'h0);
        chk("rst_gpioint", {31'h0, GPIOINT}, 32'h0);
        chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            bus_read(1'b0, 32'(i * 4), rd);
            chk($sformatf("rst_read_0x%02h", i * 4), rd, 32'h0);
        end

        // Mixed direction: low byte output, high byte input
        bus_write(1'b0, 32'h04, 32'h0000_00FF);
        bus_write(1'b0, 32'h00, 32'h0000_A5A5);
        GPIOIN = 16'h3C00;
        repeat (3) @(negedge HCLK);
        chk("mix_gpioout", {16'h0, GPIOOUT}, 32'h0000_A5A5);
        chk("mix_gpiooen", {16'h0, GPIOOEN}, 32'h0000_00FF);
        bus_read(1'b0, 32'h00, rd);
        chk("mix_data_read", rd, 32'h0000_3CA5);

        // Transfers without HREADY or with IDLE must not write
        bus_write(1'b0, 32'h04, 32'h0000_FFFF, 2'b10, 1'b0);
        chk("hready0_no_write", {16'h0, GPIOOEN}, 32'h0000_00FF);
        bus_write(1'b0, 32'h04, 32'h0000_FFFF, 2'b00, 1'b1);
        chk("idle_no_write", {16'h0, GPIOOEN}, 32'h0000_00FF);

        // Back-to-back OUTSET, OUTCLR, then reads of both
        bus_write(1'b0, 32'h00, 32'h0000_00F5);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h08;
        @(negedge HCLK);
        HWDATA = 32'h0000_0F00; HADDR = 32'h0C;
        @(negedge HCLK);
        HWDATA = 32'h0000_0005; HWRITE = 1'b0; HADDR = 32'h08;
        @(negedge HCLK);
        chk("b2b_outset_read", HRDATA, 32'h0);
        HADDR = 32'h0C;
        chk("b2b_gpioout", {16'h0, GPIOOUT}, 32'h0000_0FF0);
        @(negedge HCLK);
        chk("b2b_outclr_read", HRDATA, 32'h0);
        bus_idle();

        // Interrupt setup; INTEN written then read back-to-back
        bus_write(1'b0, 32'h04, 32'h0000_0000);
        bus_write(1'b0, 32'h14, 32'h0000_0001);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h10;
        @(negedge HCLK);
        HWDATA = 32'h0000_0003; HWRITE = 1'b0;
        @(negedge HCLK);
        chk("wr_then_rd_inten", HRDATA, 32'h0000_0003);
        bus_idle();

        // Falling pads 10..13 flag but are masked by INTEN
        GPIOIN = 16'h0002;
        repeat (4) @(negedge HCLK);
        chk("masked_gpioint", {31'h0, GPIOINT}, 32'h0);
        bus_read(1'b0, 32'h18, rd);
        chk("masked_intstat", rd, 32'h0000_3C00);
        bus_write(1'b0, 32'h18, 32'h0000_FFFF);
        bus_read(1'b0, 32'h18, rd);
        chk("intstat_cleared", rd, 32'h0);

        // bit0 rises (INTPOL=1), bit1 falls (INTPOL=0)
        GPIOIN = 16'h0001;
        repeat (4) @(negedge HCLK);
        chk("edge_gpioint", {31'h0, GPIOINT}, 32'h1);
        bus_read(1'b0, 32'h18, rd);
        chk("edge_intstat", rd, 32'h0000_0003);
        bus_write(1'b0, 32'h18, 32'h0000_0001);
        bus_read(1'b0, 32'h18, rd);
        chk("w1c_bit0_intstat", rd, 32'h0000_0002);
        chk("w1c_bit0_gpioint", {31'h0, GPIOINT}, 32'h1);
        bus_write(1'b0, 32'h18, 32'h0000_0002);
        chk("w1c_bit1_gpioint", {31'h0, GPIOINT}, 32'h0);

        // W1C of bit0 commits on the same edge its rising event is flagged
        GPIOIN = 16'h0000;
        repeat (4) @(negedge HCLK);
        GPIOIN = 16'h0001;
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h18;
        @(negedge HCLK);
        bus_idle();
        HWDATA = 32'h0000_0001;
        @(negedge HCLK);
        bus_read(1'b0, 32'h18, rd);
        chk("set_wins_intstat", rd, 32'h0000_0001);
        chk("set_wins_gpioint", {31'h0, GPIOINT}, 32'h1);

        // Reset asserted during the data phase of a DATA write
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h00;
        @(negedge HCLK);
        bus_idle();
        HWDATA = 32'h0000_FFFF;
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        chk("rstmid_gpioout", {16'h0, GPIOOUT}, 32'h0);
        @(negedge HCLK);
        chk("rstmid_gpioout_after", {16'h0, GPIOOUT}, 32'h0);
        chk("rstmid_gpioint", {31'h0, GPIOINT}, 32'h0);

        // 8-bit instance: register bits above the width read 0
        bus_write(1'b1, 32'h04, 32'hFFFF_FFFF);
        bus_read(1'b1, 32'h04, rd);
        chk("w8_dir_read", rd, 32'h0000_00FF);
        bus_write(1'b1, 32'h00, 32'hFFFF_FFFF);
        bus_read(1'b1, 32'h00, rd);
        chk("w8_data_read", rd, 32'h0000_00FF);
        chk("w8_gpioout", {24'h0, GPIOOUT8}, 32'h0000_00FF);
        chk("w8_other_untouched", {16'h0, GPIOOUT}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
